// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction fetch front end. Keeps the fetch PC and requests one word
//   per cycle from instruction memory. Each returned word is presented to
//   decode with its address and address+4. Redirects from the next-PC logic
//   retarget the fetch stream. A request that is already in flight is drained
//   and its data dropped before the new target is fetched. A misaligned
//   redirect target raises a sticky addr_err and parks the unit until reset.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   redirect_valid/_pc  one-cycle taken pulse and its target
//   stall               decode cannot accept an instruction this cycle
//   imem_req/_addr      memory request and word address (held while pending)
//   imem_ready/_rdata   request completion and returned instruction word
//   if_valid/_pc/_inst/_pc_plus4   fetched instruction toward decode
//   flush               one-cycle pulse after any accepted redirect
//   addr_err            sticky misaligned-redirect flag
//
// state | meaning
// IDLE  | dead cycle after reset, no request
// FETCH | normal fetching, one request per cycle when decode can take it
// DRAIN | redirect arrived with a request pending; wait it out, drop data
// ERR   | misaligned redirect seen; no requests until reset
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc_plus4,
  output logic        flush,
  output logic        addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_err_q, pend_err_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        flush_q, flush_d;
  logic        addr_err_q, addr_err_d;
  logic        req;
  logic        busy;
  logic        redir_bad;

  assign redir_bad = redirect_pc[1:0] != 2'b00;

  always_comb begin
    req = 1'b0;
    case (state_q)
      S_FETCH: req = !if_valid_q || !stall;
      S_DRAIN: req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  // Request issued this cycle that memory has not completed.
  assign busy = req && !imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    pend_err_d    = pend_err_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_inst_d     = if_inst_q;
    if_pc_plus4_d = if_pc_plus4_q;
    flush_d       = 1'b0;
    addr_err_d    = addr_err_q;

    case (state_q)
      S_IDLE, S_FETCH: begin
        state_d = S_FETCH;
        if (redirect_valid) begin
          flush_d    = 1'b1;
          if_valid_d = 1'b0;
          if (redir_bad) addr_err_d = 1'b1;
          if (busy) begin
            state_d    = S_DRAIN;
            pend_pc_d  = redirect_pc;
            pend_err_d = redir_bad;
          end else if (redir_bad) begin
            state_d = S_ERR;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (req && imem_ready) begin
          if_valid_d    = 1'b1;
          if_inst_d     = imem_rdata;
          if_pc_d       = pc_q;
          if_pc_plus4_d = pc_q + 32'd4;
          pc_d          = pc_q + 32'd4;
        end else if (if_valid_q && !stall) begin
          if_valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        // Once the drain is headed for ERR, later redirects no longer matter.
        if (redirect_valid && !pend_err_q) begin
          flush_d    = 1'b1;
          pend_pc_d  = redirect_pc;
          pend_err_d = redir_bad;
          if (redir_bad) addr_err_d = 1'b1;
        end
        if (imem_ready) begin
          if (pend_err_d) begin
            state_d = S_ERR;
          end else begin
            state_d = S_FETCH;
            pc_d    = pend_pc_d;
          end
        end
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= RESET_PC;
      pend_err_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'd0;
      if_inst_q     <= 32'd0;
      if_pc_plus4_q <= 32'd0;
      flush_q       <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_err_q    <= pend_err_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_inst_q     <= if_inst_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      flush_q       <= flush_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign flush       = flush_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc_plus4;
  logic        flush;
  logic        addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_pc_plus4    (if_pc_plus4),
    .flush          (flush),
    .addr_err       (addr_err)
  );

  // Reference model: started = past the dead cycle, dead = parked after a
  // misaligned target, draining = waiting out an abandoned request.
  bit          m_started, m_dead, m_draining, m_tgt_bad;
  bit          m_v, m_flush, m_aerr;
  logic [31:0] m_pc, m_tgt, m_ipc, m_inst, m_p4;

  function automatic bit m_req();
    if (m_dead || !m_started) return 1'b0;
    if (m_draining) return 1'b1;
    return !m_v || !stall;
  endfunction

  task automatic model_reset();
    m_started = 0; m_dead = 0; m_draining = 0; m_tgt_bad = 0;
    m_v = 0; m_flush = 0; m_aerr = 0;
    m_pc = 32'h0000_3000; m_tgt = 32'h0000_3000;
    m_ipc = 0; m_inst = 0; m_p4 = 0;
  endtask

  task automatic model_step();
    bit req;
    bit bad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    req = m_req();
    bad = (redirect_pc[1:0] != 2'b00);
    m_flush = 0;
    if (m_dead) return;
    if (m_draining) begin
      if (redirect_valid && !m_tgt_bad) begin
        m_flush = 1; m_tgt = redirect_pc; m_tgt_bad = bad;
        if (bad) m_aerr = 1;
      end
      if (imem_ready) begin
        m_draining = 0;
        if (m_tgt_bad) m_dead = 1;
        else m_pc = m_tgt;
      end
    end else begin
      m_started = 1;
      if (redirect_valid) begin
        m_flush = 1; m_v = 0;
        if (bad) m_aerr = 1;
        if (req && !imem_ready) begin
          m_draining = 1; m_tgt = redirect_pc; m_tgt_bad = bad;
        end else if (bad) begin
          m_dead = 1;
        end else begin
          m_pc = redirect_pc;
        end
      end else if (req && imem_ready) begin
        m_v = 1; m_inst = imem_rdata; m_ipc = m_pc;
        m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end else if (m_v && !stall) begin
        m_v = 0;
      end
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: apply inputs, then check the request side.
  task automatic drive(input bit rn, input bit rv, input logic [31:0] rp,
                       input bit st, input bit rdy);
    rst_n = rn; redirect_valid = rv; redirect_pc = rp;
    stall = st; imem_ready = rdy; imem_rdata = $urandom;
    #1;
    chk1("m_imem_req", imem_req, m_req());
    if (m_req()) chk32("m_imem_addr", imem_addr, m_pc);
  endtask

  // Clock edge, model update, then check registered outputs.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk1("m_if_valid", if_valid, m_v);
    chk1("m_flush", flush, m_flush);
    chk1("m_addr_err", addr_err, m_aerr);
    chk32("m_if_pc", if_pc, m_ipc);
    chk32("m_if_inst", if_inst, m_inst);
    chk32("m_if_pc_plus4", if_pc_plus4, m_p4);
  endtask

  task automatic do_reset();
    drive(0, 0, 32'h0, 0, 0); step();
    drive(0, 0, 32'h0, 0, 0); step();
  endtask

  initial begin
    rst_n = 0; redirect_valid = 0; redirect_pc = 0;
    stall = 0; imem_ready = 0; imem_rdata = 0;
    @(posedge clk); #1;
    model_reset();

    // Reset state
    do_reset();
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_flush", flush, 1'b0);
    chk1("rst_addr_err", addr_err, 1'b0);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk32("rst_if_pc", if_pc, 32'h0);
    chk32("rst_if_inst", if_inst, 32'h0);
    chk32("rst_if_pc_plus4", if_pc_plus4, 32'h0);

    // Start-up latency and back-to-back fetch
    drive(1, 0, 32'h0, 0, 1); chk1("idle_no_req", imem_req, 1'b0); step();
    chk1("idle_no_valid", if_valid, 1'b0);
    drive(1, 0, 32'h0, 0, 1); chk1("first_req", imem_req, 1'b1);
    chk32("addr_3000", imem_addr, 32'h3000); step();
    chk1("first_valid", if_valid, 1'b1); chk32("ifpc_3000", if_pc, 32'h3000);
    chk32("p4_3004", if_pc_plus4, 32'h3004);
    drive(1, 0, 32'h0, 0, 1); chk32("addr_3004", imem_addr, 32'h3004); step();
    chk32("ifpc_3004", if_pc, 32'h3004);
    drive(1, 0, 32'h0, 0, 1); chk32("addr_3008", imem_addr, 32'h3008); step();
    chk32("ifpc_3008", if_pc, 32'h3008);

    // Stall hold at if_pc 0x3004
    do_reset();
    drive(1, 0, 32'h0, 0, 1); step();
    drive(1, 0, 32'h0, 0, 1); step();
    drive(1, 0, 32'h0, 0, 1); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h0, 1, 1); chk1("stall_no_req", imem_req, 1'b0); step();
      chk1("stall_hold_valid", if_valid, 1'b1); chk32("stall_hold_pc", if_pc, 32'h3004);
    end
    drive(1, 0, 32'h0, 0, 1); chk32("unstall_addr", imem_addr, 32'h3008); step();
    chk32("unstall_ifpc", if_pc, 32'h3008);

    // Redirect while the request completes
    drive(1, 1, 32'h3100, 0, 1); step();
    chk1("redir_flush", flush, 1'b1); chk1("redir_kill", if_valid, 1'b0);
    drive(1, 0, 32'h0, 0, 1); chk32("redir_addr", imem_addr, 32'h3100); step();
    chk1("flush_one_cycle", flush, 1'b0); chk32("redir_ifpc", if_pc, 32'h3100);

    // Redirect with a pending request: drain then retarget
    drive(1, 1, 32'h3010, 0, 1); step();
    drive(1, 1, 32'h3200, 0, 0); chk32("drain_addr0", imem_addr, 32'h3010); step();
    chk1("drain_flush", flush, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 32'h0, 0, 0); chk1("drain_req", imem_req, 1'b1);
      chk32("drain_addr_hold", imem_addr, 32'h3010); step();
      chk1("drain_no_valid", if_valid, 1'b0);
    end
    drive(1, 0, 32'h0, 0, 1); chk32("drain_addr_last", imem_addr, 32'h3010); step();
    chk1("drain_dropped", if_valid, 1'b0);
    drive(1, 0, 32'h0, 0, 1); chk32("post_drain_addr", imem_addr, 32'h3200); step();
    chk32("post_drain_ifpc", if_pc, 32'h3200);

    // Second redirect during drain: latest target wins
    drive(1, 0, 32'h0, 0, 0); step();
    drive(1, 1, 32'h3400, 0, 0); step();
    drive(1, 1, 32'h3500, 0, 0); chk32("drain2_hold", imem_addr, 32'h3204); step();
    chk1("drain2_flush", flush, 1'b1);
    drive(1, 0, 32'h0, 0, 1); step();
    drive(1, 0, 32'h0, 0, 1); chk32("latest_wins", imem_addr, 32'h3500); step();

    // Address wrap
    drive(1, 1, 32'hFFFF_FFFC, 0, 1); step();
    drive(1, 0, 32'h0, 0, 1); chk32("wrap_addr0", imem_addr, 32'hFFFF_FFFC); step();
    chk32("wrap_ifpc", if_pc, 32'hFFFF_FFFC); chk32("wrap_p4", if_pc_plus4, 32'h0);
    drive(1, 0, 32'h0, 0, 1); chk32("wrap_addr1", imem_addr, 32'h0); step();
    chk32("wrap_ifpc1", if_pc, 32'h0);

    // Misaligned redirect: sticky error, later redirects ignored
    drive(1, 1, 32'h3102, 0, 1); step();
    chk1("mis_err", addr_err, 1'b1); chk1("mis_flush", flush, 1'b1);
    chk1("mis_kill", if_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h3000, 0, 1); chk1("err_no_req", imem_req, 1'b0); step();
      chk1("err_sticky", addr_err, 1'b1); chk1("err_no_flush", flush, 1'b0);
    end
    do_reset();
    chk1("err_cleared", addr_err, 1'b0);
    drive(1, 0, 32'h0, 0, 1); step();
    drive(1, 0, 32'h0, 0, 1); chk32("recover_addr", imem_addr, 32'h3000); step();

    // Misaligned redirect with a pending request: drain first, then park
    do_reset();
    drive(1, 0, 32'h0, 0, 1); step();
    drive(1, 1, 32'h3006, 0, 0); chk32("mis_drain_addr", imem_addr, 32'h3000); step();
    chk1("mis_drain_err", addr_err, 1'b1);
    drive(1, 0, 32'h0, 0, 0); chk1("mis_drain_req", imem_req, 1'b1); step();
    drive(1, 0, 32'h0, 0, 1); chk1("mis_drain_req2", imem_req, 1'b1); step();
    drive(1, 0, 32'h0, 0, 1); chk1("mis_parked", imem_req, 1'b0); step();

    // Reset during a pending request
    do_reset();
    drive(1, 0, 32'h0, 0, 1); step();
    drive(1, 0, 32'h0, 0, 0); step();
    drive(0, 0, 32'h0, 0, 1); step();
    chk1("rst_mid_valid", if_valid, 1'b0); chk32("rst_mid_ifpc", if_pc, 32'h0);

    // Randomized traffic
    for (int seg = 0; seg < 16; seg++) begin
      do_reset();
      for (int c = 0; c < 160; c++) begin
        logic [31:0] rp;
        bit          rv;
        rv = ($urandom_range(0, 99) < 12);
        rp = $urandom & 32'h0000_3FFC;
        if ($urandom_range(0, 9) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        if ($urandom_range(0, 49) == 0) rp[1:0] = 2'($urandom_range(1, 3));
        drive(($urandom_range(0, 199) != 0), rv, rp,
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
